// File: rtl/miniled_serial_rx.sv
// miniled_serial_rx
//   Receive-side decoder for the MiniLED panel serial interface. Oversamples
//   DCLK/SDI/LE/scan on the system clock, rebuilds brightness words tagged with
//   their absolute LED index, and checks each latch for framing errors.
// Ports
//   I_clk, I_rst        system clock, synchronous active-high reset
//   I_dclk, I_sdi       serial shift clock (sampled on rising edge) and data
//   I_le                latch enable, rising edge closes a scan line
//   I_scan              one-hot scan select {scan4..scan1}
//   O_word_valid        1-cycle pulse, O_word / O_led_idx valid
//   O_word, O_led_idx   reconstructed word and scan*WORDS_PER + word position
//   O_latch             1-cycle pulse per accepted LE rise
//   O_latch_bits        bits received since previous LE, valid with O_latch
//   O_frame_done        pulse with O_latch while scan4 is selected
//   O_err               sticky {scan_err, partial_err, count_err}
module miniled_serial_rx #(
  parameter int WORD_W    = 8,
  parameter int WORDS_PER = 90,
  parameter int N_SCAN    = 4,
  parameter int CNT_W     = 12
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_dclk,
  input  logic              I_sdi,
  input  logic              I_le,
  input  logic [N_SCAN-1:0] I_scan,
  output logic              O_word_valid,
  output logic [WORD_W-1:0] O_word,
  output logic [8:0]        O_led_idx,
  output logic              O_latch,
  output logic [CNT_W-1:0]  O_latch_bits,
  output logic              O_frame_done,
  output logic [2:0]        O_err
);

  localparam int BIN_W = (N_SCAN > 1) ? $clog2(N_SCAN) : 1;
  localparam int POS_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WC_W  = (WORDS_PER > 1) ? $clog2(WORDS_PER) : 1;
  localparam logic [CNT_W-1:0]  LINE_BITS = CNT_W'(WORD_W * WORDS_PER);
  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(WORD_W - 1);
  localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(WORDS_PER - 1);
  localparam logic [N_SCAN-1:0] LAST_SCAN = N_SCAN'(1) << (N_SCAN - 1);

  // Synchronisers: [0],[1] are the 2-flop sync, [2] is the edge-detect delay.
  logic [2:0]        dclk_s;
  logic [2:0]        le_s;
  logic [1:0]        sdi_s;
  logic [N_SCAN-1:0] scan_s1, scan_s2;
  logic [1:0]        arm_cnt;
  logic              armed;

  // Registered edge events; all line state is updated from this stage so a
  // simultaneous DCLK/LE pair lands in the same cycle.
  logic              ev_dclk, ev_le, ev_sdi;
  logic [N_SCAN-1:0] ev_scan;

  logic [WORD_W-1:0] shift_reg, shift_nx;
  logic [CNT_W-1:0]  bit_cnt, bits_nx;
  logic [POS_W-1:0]  bit_pos, pos_nx;
  logic [WC_W-1:0]   word_cnt;
  logic              word_done;

  logic              scan_ok;
  logic [BIN_W-1:0]  scan_bin;
  logic [8:0]        scan_base;
  int unsigned       ones;

  assign armed = (arm_cnt == 2'd3);

  always_comb begin
    ones     = 0;
    scan_bin = '0;
    for (int unsigned i = 0; i < N_SCAN; i++) begin
      if (ev_scan[i]) begin
        ones     = ones + 1;
        scan_bin = BIN_W'(i);
      end
    end
    scan_ok   = (ones == 1);
    scan_base = scan_ok ? 9'(scan_bin * WORDS_PER) : '0;
  end

  // The bit taken on this event is folded in before any latch handling.
  always_comb begin
    shift_nx  = shift_reg;
    bits_nx   = bit_cnt;
    pos_nx    = bit_pos;
    word_done = 1'b0;
    if (ev_dclk) begin
      shift_nx  = {shift_reg[WORD_W-2:0], ev_sdi};
      bits_nx   = (&bit_cnt) ? bit_cnt : bit_cnt + 1'b1;
      word_done = (bit_pos == LAST_POS);
      pos_nx    = word_done ? '0 : bit_pos + 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      dclk_s       <= '0;
      le_s         <= '0;
      sdi_s        <= '0;
      scan_s1      <= '0;
      scan_s2      <= '0;
      arm_cnt      <= '0;
      ev_dclk      <= 1'b0;
      ev_le        <= 1'b0;
      ev_sdi       <= 1'b0;
      ev_scan      <= '0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      bit_pos      <= '0;
      word_cnt     <= '0;
      O_word_valid <= 1'b0;
      O_word       <= '0;
      O_led_idx    <= '0;
      O_latch      <= 1'b0;
      O_latch_bits <= '0;
      O_frame_done <= 1'b0;
      O_err        <= '0;
    end else begin
      dclk_s  <= {dclk_s[1:0], I_dclk};
      le_s    <= {le_s[1:0], I_le};
      sdi_s   <= {sdi_s[0], I_sdi};
      scan_s1 <= I_scan;
      scan_s2 <= scan_s1;
      // Hold off edge detection until the delay flop has caught up with the
      // post-reset input level.
      if (!armed) arm_cnt <= arm_cnt + 1'b1;

      ev_dclk <= armed & dclk_s[1] & ~dclk_s[2];
      ev_le   <= armed & le_s[1] & ~le_s[2];
      ev_sdi  <= sdi_s[1];
      ev_scan <= scan_s2;

      O_word_valid <= 1'b0;
      O_latch      <= 1'b0;
      O_frame_done <= 1'b0;

      if ((ev_dclk || ev_le) && !scan_ok) O_err[2] <= 1'b1;

      if (ev_dclk) begin
        shift_reg <= shift_nx;
        bit_cnt   <= bits_nx;
        bit_pos   <= pos_nx;
        if (word_done) begin
          O_word_valid <= 1'b1;
          O_word       <= shift_nx;
          // word_cnt parks on the last slot, clamping overlong lines.
          O_led_idx    <= scan_base + 9'(word_cnt);
          if (word_cnt != LAST_WORD) word_cnt <= word_cnt + 1'b1;
        end
      end

      // Placed after the shift so the line clear wins on a shared cycle.
      if (ev_le) begin
        O_latch      <= 1'b1;
        O_latch_bits <= bits_nx;
        O_frame_done <= (ev_scan == LAST_SCAN);
        if (bits_nx != LINE_BITS) O_err[0] <= 1'b1;
        if (pos_nx != '0)         O_err[1] <= 1'b1;
        shift_reg <= '0;
        bit_cnt   <= '0;
        bit_pos   <= '0;
        word_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_miniled_serial_rx.sv
// tb_miniled_serial_rx
//   Self-checking bench for miniled_serial_rx: a table of scan lines plus hand
//   sequences for simultaneous DCLK/LE and reset mid-line. Expected words and
//   latches are queued as stimulus is driven and checked as the DUT emits them.
module tb_miniled_serial_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dclk = 1'b0;
  logic        sdi = 1'b0;
  logic        le = 1'b0;
  logic [3:0]  scan = 4'b0001;
  logic        word_valid;
  logic [7:0]  word;
  logic [8:0]  led_idx;
  logic        latch;
  logic [11:0] latch_bits;
  logic        frame_done;
  logic [2:0]  err;

  miniled_serial_rx #(.WORD_W(8), .WORDS_PER(90), .N_SCAN(4), .CNT_W(12)) dut (
    .I_clk(clk), .I_rst(rst), .I_dclk(dclk), .I_sdi(sdi), .I_le(le), .I_scan(scan),
    .O_word_valid(word_valid), .O_word(word), .O_led_idx(led_idx),
    .O_latch(latch), .O_latch_bits(latch_bits), .O_frame_done(frame_done), .O_err(err)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int words_seen = 0;
  int latches_seen = 0;
  int last_word_cyc = -1;
  int last_latch_cyc = -2;

  logic [16:0] wq[$];   // {word, idx}
  logic [12:0] lq[$];   // {latch_bits, frame_done}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_base(input logic [3:0] s);
    int n = 0;
    int pos = 0;
    for (int i = 0; i < 4; i++) if (s[i]) begin n++; pos = i; end
    return (n == 1) ? pos * 90 : 0;
  endfunction

  // Output monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (word_valid) begin
      words_seen++;
      last_word_cyc = cyc;
      if (wq.size() == 0) begin
        tests++; fails++;
        $display("FAIL word_unexpected: got word %0h idx %0d, required no word", word, led_idx);
      end else begin
        logic [16:0] e;
        e = wq.pop_front();
        check("word_idx", {word, led_idx}, e);
      end
    end
    if (latch) begin
      latches_seen++;
      last_latch_cyc = cyc;
      if (lq.size() == 0) begin
        tests++; fails++;
        $display("FAIL latch_unexpected: got bits %0d, required no latch", latch_bits);
      end else begin
        logic [12:0] e;
        e = lq.pop_front();
        check("latch_bits_fd", {latch_bits, frame_done}, e);
      end
    end
    if (frame_done && !latch) begin
      tests++; fails++;
      $display("FAIL frame_done_alone: got 1, required 0");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Shift nbits at 12.5 MHz (2 low, 2 high). Optionally raise LE together
  // with the last DCLK rise.
  task automatic send_bits(input int nbits, input logic [3:0] s, input bit idx_pat,
                           input logic [7:0] fill, input bit merge_le);
    int base;
    int w;
    logic [7:0] d;
    base = model_base(s);
    scan = s;
    for (int i = 0; i < nbits; i++) begin
      w = i / 8;
      d = idx_pat ? 8'(w) : fill;
      if (i % 8 == 7) wq.push_back({d, 9'(base + ((w > 89) ? 89 : w))});
      dclk = 1'b0;
      sdi  = d[7 - (i % 8)];
      repeat (2) @(negedge clk);
      dclk = 1'b1;
      if (merge_le && i == nbits - 1) begin
        le = 1'b1;
        lq.push_back({12'(nbits), s == 4'b1000});
      end
      repeat (2) @(negedge clk);
    end
    le = 1'b0;
  endtask

  task automatic pulse_le(input int bits, input logic [3:0] s);
    lq.push_back({12'(bits), s == 4'b1000});
    le = 1'b1;
    repeat (2) @(negedge clk);
    le = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (10) @(negedge clk);
    check({tag, "_words_left"}, wq.size(), 0);
    check({tag, "_latches_left"}, lq.size(), 0);
  endtask

  typedef struct {
    bit         rst_before;
    int         nbits;
    logic [3:0] scan;
    bit         idx_pat;
    logic [7:0] fill;
    logic [11:0] exp_bits;
    logic [2:0] exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int wb, lb;
    vecs[0] = '{1'b1, 720, 4'b0001, 1'b1, 8'h00, 12'd720, 3'b000};
    vecs[1] = '{1'b1, 720, 4'b0001, 1'b0, 8'hA5, 12'd720, 3'b000};
    vecs[2] = '{1'b0, 720, 4'b0010, 1'b0, 8'hA5, 12'd720, 3'b000};
    vecs[3] = '{1'b0, 720, 4'b0100, 1'b0, 8'hA5, 12'd720, 3'b000};
    vecs[4] = '{1'b0, 720, 4'b1000, 1'b0, 8'hA5, 12'd720, 3'b000};
    vecs[5] = '{1'b1, 723, 4'b0001, 1'b1, 8'h00, 12'd723, 3'b011};
    vecs[6] = '{1'b1, 16,  4'b0100, 1'b1, 8'h00, 12'd16,  3'b001};
    vecs[7] = '{1'b1, 720, 4'b0011, 1'b1, 8'h00, 12'd720, 3'b100};
    vecs[8] = '{1'b0, 720, 4'b0001, 1'b1, 8'h00, 12'd720, 3'b100};

    do_reset();
    check("rst_word_valid", word_valid, 0);
    check("rst_word", word, 0);
    check("rst_led_idx", led_idx, 0);
    check("rst_latch", latch, 0);
    check("rst_latch_bits", latch_bits, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].rst_before) do_reset();
      send_bits(vecs[v].nbits, vecs[v].scan, vecs[v].idx_pat, vecs[v].fill, 1'b0);
      pulse_le(vecs[v].exp_bits, vecs[v].scan);
      drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
    end

    // Last DCLK rise and LE rise in the same cycle.
    do_reset();
    send_bits(720, 4'b0001, 1'b1, 8'h00, 1'b1);
    drain("simul");
    check("simul_same_cycle", last_word_cyc, last_latch_cyc);
    check("simul_err", err, 0);

    // Inputs high through reset release, then reset mid-line.
    dclk = 1'b1;
    le   = 1'b1;
    wb = words_seen;
    lb = latches_seen;
    do_reset();
    repeat (6) @(negedge clk);
    le = 1'b0;
    repeat (6) @(negedge clk);
    check("release_no_word", words_seen - wb, 0);
    check("release_no_latch", latches_seen - lb, 0);
    send_bits(300, 4'b0001, 1'b1, 8'h00, 1'b0);
    lb = latches_seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    drain("abort");
    check("abort_no_latch", latches_seen - lb, 0);
    check("abort_err", err, 0);
    send_bits(720, 4'b0001, 1'b1, 8'h00, 1'b0);
    pulse_le(720, 4'b0001);
    drain("after_abort");
    check("after_abort_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
